mem_arbiter: RTL and testbench

- Shares the single memory unit port (ROM + RAM behind one address/we/data interface) between the instruction-fetch requester (I) and the load/store requester (D).
- Arbitrates round-robin and sequences each access over a fixed read latency.
- Checks every request against the system memory map and answers illegal accesses with an error response; illegal accesses never reach memory.
- Sits between the CPU core's fetch/LSU and memory_unit.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory-unit port (ROM + RAM behind one address/we/data
// interface) between the instruction-fetch requester (I) and the load/store
// requester (D). Conflicts are resolved round-robin. Every request is checked
// against the system memory map, and an illegal request is answered with an
// error response without ever touching memory.
//
// Parameters
//   N        address/data width (upper 16 bits form the region selector)
//   LATENCY  memory read latency in cycles (>=1); cycles spent in ACCESS
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   i_req/i_addr       fetch request, held until i_ack
//   i_ack/i_data/i_err one-cycle fetch response
//   d_req/d_we/d_addr/d_wdata   load/store request, held until d_ack
//   d_ack/d_rdata/d_err         one-cycle load/store response
//   mem_we/mem_addr/mem_data_write/mem_data_read   memory-unit port
//   busy               high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int N       = 32,
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         i_req,
    input  logic [N-1:0] i_addr,
    output logic         i_ack,
    output logic [N-1:0] i_data,
    output logic         i_err,

    input  logic         d_req,
    input  logic         d_we,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic         d_ack,
    output logic [N-1:0] d_rdata,
    output logic         d_err,

    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_data_write,
    input  logic [N-1:0] mem_data_read,

    output logic         busy
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_START = CW'(LATENCY - 1);

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            last_grant;
    logic            gnt;
    logic [N-1:0]    lat_addr;
    logic            lat_we;
    logic [N-1:0]    lat_wdata;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    resp_data;
    logic            resp_err;

    logic            grant_d;
    logic [N-1:0]    sel_addr;
    logic            sel_we;
    logic [N-1:0]    sel_wdata;
    logic            fault;

    // Memory-map legality check on the upper 16 address bits plus alignment.
    // Region 0x0000 is reserved, 0x0001..0x000F is ROM (read-only),
    // 0xFF10 and above is reserved.
    function automatic logic is_fault(input logic [N-1:0] addr, input logic we);
        logic [15:0] region;
        region = addr[N-1:N-16];
        return (region == 16'h0000) ||
               (region >= 16'hFF10) ||
               (we && (region <= 16'h000F)) ||
               (addr[1:0] != 2'b00);
    endfunction

    // Grant selection: a lone requester wins; on a conflict the requester
    // that did not win last time is chosen.
    always_comb begin
        grant_d = d_req;
        if (i_req && d_req) begin
            grant_d = (last_grant == GNT_I);
        end
        sel_addr  = grant_d ? d_addr  : i_addr;
        sel_we    = grant_d & d_we;
        sel_wdata = grant_d ? d_wdata : '0;
        fault     = is_fault(sel_addr, sel_we);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt = fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GNT_D;
            gnt        <= GNT_I;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            cnt        <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        gnt        <= grant_d;
                        last_grant <= grant_d;
                        lat_addr   <= sel_addr;
                        lat_we     <= sel_we;
                        lat_wdata  <= sel_wdata;
                        cnt        <= CNT_START;
                        resp_data  <= '0;
                        resp_err   <= fault;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        resp_data <= lat_we ? '0 : mem_data_read;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: responses are gated by their ack so data/err read 0 otherwise.
    // The write strobe fires only in the first ACCESS cycle (counter still at
    // its start value).
    always_comb begin
        i_ack          = (state == RESP) && (gnt == GNT_I);
        d_ack          = (state == RESP) && (gnt == GNT_D);
        i_data         = i_ack ? resp_data : '0;
        i_err          = i_ack & resp_err;
        d_rdata        = d_ack ? resp_data : '0;
        d_err          = d_ack & resp_err;
        mem_we         = (state == ACCESS) && lat_we && (cnt == CNT_START);
        mem_addr       = lat_addr;
        mem_data_write = lat_wdata;
        busy           = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiter instances: u_dut1 (LATENCY=1) and u_dut3 (LATENCY=3). Each has
// its own expected-response queue; a monitor pops an entry whenever the DUT
// presents an ack and compares requester id, data, error flag and cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q1[$];
    exp_t q3[$];
    int   we_cnt1 = 0;
    int   we_cnt3 = 0;

    // DUT1 signals (LATENCY=1)
    logic        rst1;
    logic        i_req1, d_req1, d_we1;
    logic [31:0] i_addr1, d_addr1, d_wdata1;
    logic        i_ack1, i_err1, d_ack1, d_err1;
    logic [31:0] i_data1, d_rdata1;
    logic        mem_we1, busy1;
    logic [31:0] mem_addr1, mem_wd1, mem_rd1;

    // DUT3 signals (LATENCY=3)
    logic        rst3;
    logic        i_req3, d_req3, d_we3;
    logic [31:0] i_addr3, d_addr3, d_wdata3;
    logic        i_ack3, i_err3, d_ack3, d_err3;
    logic [31:0] i_data3, d_rdata3;
    logic        mem_we3, busy3;
    logic [31:0] mem_addr3, mem_wd3, mem_rd3;

    // DUT3 memory returns a value that changes every cycle, so the captured
    // word identifies exactly which ACCESS cycle it was taken in.
    function automatic logic [31:0] f3(input int c);
        return 32'hC0DE_0000 | (32'(c) & 32'h0000_FFFF);
    endfunction
    assign mem_rd3 = f3(cyc);

    mem_arbiter #(.N(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_data(i_data1), .i_err(i_err1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data_write(mem_wd1),
        .mem_data_read(mem_rd1), .busy(busy1)
    );

    mem_arbiter #(.N(32), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_data(i_data3), .i_err(i_err3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3), .d_err(d_err3),
        .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_data_write(mem_wd3),
        .mem_data_read(mem_rd3), .busy(busy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push1(input logic is_d, input logic [31:0] data, input logic err, input int c);
        exp_t e;
        e.is_d = is_d; e.data = data; e.err = err; e.cyc = c;
        q1.push_back(e);
    endtask

    task automatic push3(input logic is_d, input logic [31:0] data, input logic err, input int c);
        exp_t e;
        e.is_d = is_d; e.data = data; e.err = err; e.cyc = c;
        q3.push_back(e);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (i_ack1 || d_ack1) begin
            check("dut1_ack_overlap", 32'(i_ack1 && d_ack1), 32'd0);
            check("dut1_ack_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("dut1_ack_is_d", 32'(d_ack1), 32'(e.is_d));
                check("dut1_data", d_ack1 ? d_rdata1 : i_data1, e.data);
                check("dut1_err", 32'(d_ack1 ? d_err1 : i_err1), 32'(e.err));
                check("dut1_ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("dut1_idle_resp_zero", 32'(i_data1 | d_rdata1) | 32'(i_err1 | d_err1), 32'd0);
        end
        if (i_ack3 || d_ack3) begin
            check("dut3_ack_overlap", 32'(i_ack3 && d_ack3), 32'd0);
            check("dut3_ack_expected", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                check("dut3_ack_is_d", 32'(d_ack3), 32'(e.is_d));
                check("dut3_data", d_ack3 ? d_rdata3 : i_data3, e.data);
                check("dut3_err", 32'(d_ack3 ? d_err3 : i_err3), 32'(e.err));
                check("dut3_ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check("dut3_idle_resp_zero", 32'(i_data3 | d_rdata3) | 32'(i_err3 | d_err3), 32'd0);
        end
        if (mem_we1) we_cnt1++;
        if (mem_we3) we_cnt3++;
    end

    // Watchdog
    initial begin
        #20000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Fault case on DUT1: one ack cycle after sampling, err=1, data=0
    task automatic fault1(input string name, input logic is_d, input logic we,
                          input logic [31:0] addr);
        int s;
        s = cyc;
        if (is_d) begin
            d_req1 = 1'b1; d_we1 = we; d_addr1 = addr; d_wdata1 = 32'hAAAA_5555;
        end else begin
            i_req1 = 1'b1; i_addr1 = addr;
        end
        push1(is_d, 32'h0, 1'b1, s + 1);
        at(s + 1);
        check({name, "_busy"}, 32'(busy1), 32'd1);
        check({name, "_mem_we"}, 32'(mem_we1), 32'd0);
        i_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0;
        at(s + 2);
        check({name, "_idle"}, 32'(busy1), 32'd0);
    endtask

    int s;
    int we_snap;

    initial begin
        rst1 = 1'b0; rst3 = 1'b0;
        i_req1 = 0; d_req1 = 0; d_we1 = 0; i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;
        i_req3 = 0; d_req3 = 0; d_we3 = 0; i_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;
        mem_rd1 = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        check("reset_busy1", 32'(busy1), 32'd0);
        check("reset_mem_we1", 32'(mem_we1), 32'd0);
        check("reset_mem_addr1", mem_addr1, 32'd0);
        check("reset_mem_wd1", mem_wd1, 32'd0);
        check("reset_busy3", 32'(busy3), 32'd0);
        check("reset_acks", 32'({i_ack1, d_ack1, i_ack3, d_ack3}), 32'd0);
        rst1 = 1'b1; rst3 = 1'b1;
        @(negedge clk);

        // Round robin: both request together right after reset, held.
        s = cyc;
        i_req1 = 1'b1; i_addr1 = 32'h0001_0004;
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h0010_0008;
        push1(1'b0, 32'hDEAD_BEEF, 1'b0, s + 2);
        push1(1'b1, 32'hDEAD_BEEF, 1'b0, s + 5);
        push1(1'b0, 32'hDEAD_BEEF, 1'b0, s + 8);
        push1(1'b1, 32'hDEAD_BEEF, 1'b0, s + 11);
        at(s + 1);
        check("rr_first_addr", mem_addr1, 32'h0001_0004);
        at(s + 3);
        check("rr_gap_busy", 32'(busy1), 32'd0);
        at(s + 4);
        check("rr_second_busy", 32'(busy1), 32'd1);
        check("rr_second_addr", mem_addr1, 32'h0010_0008);
        at(s + 6);
        check("rr_gap2_busy", 32'(busy1), 32'd0);
        at(s + 8);
        i_req1 = 1'b0;
        at(s + 11);
        d_req1 = 1'b0;
        at(s + 12);

        // Single I read
        s = cyc;
        i_req1 = 1'b1; i_addr1 = 32'h0001_0004;
        push1(1'b0, 32'hDEAD_BEEF, 1'b0, s + 2);
        at(s + 1);
        check("iread_mem_addr", mem_addr1, 32'h0001_0004);
        check("iread_mem_we", 32'(mem_we1), 32'd0);
        at(s + 2);
        i_req1 = 1'b0;
        at(s + 3);
        check("iread_idle", 32'(busy1), 32'd0);

        // Single D write
        s = cyc;
        we_snap = we_cnt1;
        d_req1 = 1'b1; d_we1 = 1'b1; d_addr1 = 32'h0010_0008; d_wdata1 = 32'h1234_5678;
        push1(1'b1, 32'h0, 1'b0, s + 2);
        at(s + 1);
        check("dwrite_mem_we", 32'(mem_we1), 32'd1);
        check("dwrite_mem_addr", mem_addr1, 32'h0010_0008);
        check("dwrite_mem_wd", mem_wd1, 32'h1234_5678);
        at(s + 2);
        check("dwrite_we_low", 32'(mem_we1), 32'd0);
        d_req1 = 1'b0; d_we1 = 1'b0;
        at(s + 3);
        check("dwrite_we_once", 32'(we_cnt1 - we_snap), 32'd1);
        check("dwrite_hold_addr", mem_addr1, 32'h0010_0008);

        // Faults: no memory write may occur
        we_snap = we_cnt1;
        fault1("f_rom_write", 1'b1, 1'b1, 32'h0002_0000);
        fault1("f_low_read", 1'b1, 1'b0, 32'h0000_1000);
        fault1("f_high_read", 1'b0, 1'b0, 32'hFF10_0000);
        fault1("f_misaligned", 1'b1, 1'b0, 32'h0010_0002);
        fault1("f_rom_write_top", 1'b1, 1'b1, 32'h000F_FFFC);
        check("fault_no_mem_we", 32'(we_cnt1 - we_snap), 32'd0);

        // Legal boundary: last word below the reserved high region
        s = cyc;
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'hFF0F_FFFC;
        push1(1'b1, 32'hDEAD_BEEF, 1'b0, s + 2);
        at(s + 2);
        d_req1 = 1'b0;
        at(s + 3);

        // LATENCY=3 D read: data taken in the third ACCESS cycle
        s = cyc;
        d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h0010_0000;
        push3(1'b1, f3(s + 3), 1'b0, s + 4);
        at(s + 1);
        check("l3_busy_a1", 32'(busy3), 32'd1);
        check("l3_mem_addr", mem_addr3, 32'h0010_0000);
        at(s + 3);
        check("l3_busy_a3", 32'(busy3), 32'd1);
        check("l3_mem_we", 32'(mem_we3), 32'd0);
        at(s + 4);
        d_req3 = 1'b0;
        at(s + 5);

        // Reset mid-ACCESS of a D write
        s = cyc;
        d_req3 = 1'b1; d_we3 = 1'b1; d_addr3 = 32'h0010_0000; d_wdata3 = 32'h55AA_55AA;
        at(s + 1);
        check("rst_pre_we", 32'(mem_we3), 32'd1);
        at(s + 2);
        rst3 = 1'b0;
        #1;
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_mem_we", 32'(mem_we3), 32'd0);
        check("rst_mem_addr", mem_addr3, 32'd0);
        check("rst_mem_wd", mem_wd3, 32'd0);
        check("rst_d_ack", 32'({d_ack3, d_err3}), 32'd0);
        check("rst_d_rdata", d_rdata3, 32'd0);
        at(s + 3);
        d_req3 = 1'b0; d_we3 = 1'b0;
        at(s + 4);
        rst3 = 1'b1;
        at(s + 5);
        we_snap = we_cnt3;
        i_req3 = 1'b1; i_addr3 = 32'h0001_0004;
        d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h0010_0008;
        push3(1'b0, f3(s + 8), 1'b0, s + 9);
        push3(1'b1, f3(s + 13), 1'b0, s + 14);
        at(s + 6);
        check("post_rst_i_addr", mem_addr3, 32'h0001_0004);
        at(s + 9);
        i_req3 = 1'b0;
        at(s + 14);
        d_req3 = 1'b0;
        at(s + 16);
        check("post_rst_no_we", 32'(we_cnt3 - we_snap), 32'd0);

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
